// File: rtl/dec_stream.sv
// dec_stream: streaming registered decrementer with a valid/ready handshake on
// both sides. Each accepted word yields in_data - STEP plus a borrow flag.
// Results are held in a two-entry buffer: a main register that drives the
// outputs and a skid register behind it. This keeps full throughput under
// backpressure while in_ready stays a registered signal.
//
// state | meaning
// ------+-----------------------------------------------
// EMPTY | no result held, outputs idle
// ONE   | main register holds the result being offered
// FULL  | main and skid both hold results, input stalled
module dec_stream #(
  parameter int WIDTH    = 8,
  parameter int STEP     = 1,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_borrow,
  output logic [7:0]       underflow_cnt
);

  // State encoding is {main valid, skid valid}.
  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] ONE   = 2'b10;
  localparam logic [1:0] FULL  = 2'b11;

  localparam logic [WIDTH-1:0] STEP_W = STEP[WIDTH-1:0];

  logic [1:0]       state;
  logic [WIDTH-1:0] m_data;
  logic             m_borrow;
  logic [WIDTH-1:0] s_data;
  logic             s_borrow;

  logic             in_fire;
  logic             out_fire;
  logic             new_borrow;
  logic [WIDTH-1:0] new_diff;
  logic [WIDTH-1:0] new_data;

  // Both flags come straight from state flops, so in_ready is registered.
  assign in_ready   = ~state[0];
  assign out_valid  = state[1];
  assign out_data   = m_data;
  assign out_borrow = m_borrow;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Compute the result on the incoming word, so it is stored with the word.
  always_comb begin
    new_borrow = (in_data < STEP_W);
    new_diff   = in_data - STEP_W;
    new_data   = new_diff;
    if ((SATURATE != 0) && new_borrow) begin
      new_data = '0;
    end
  end

  // Buffer occupancy and data movement between the main and skid registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      m_data   <= '0;
      m_borrow <= 1'b0;
      s_data   <= '0;
      s_borrow <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            m_data   <= new_data;
            m_borrow <= new_borrow;
            state    <= ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            m_data   <= new_data;
            m_borrow <= new_borrow;
          end else if (in_fire) begin
            s_data   <= new_data;
            s_borrow <= new_borrow;
            state    <= FULL;
          end else if (out_fire) begin
            state    <= EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only the output side can move.
          if (out_fire) begin
            m_data   <= s_data;
            m_borrow <= s_borrow;
            state    <= ONE;
          end
        end
        default: begin
          state <= EMPTY;
        end
      endcase
    end
  end

  // Count borrowed results as they leave; hold at 255 rather than wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      underflow_cnt <= 8'd0;
    end else if (out_fire && m_borrow && (underflow_cnt != 8'hFF)) begin
      underflow_cnt <= underflow_cnt + 8'd1;
    end
  end

endmodule

// File: doc/dec_stream.md
Name: dec_stream

Overview:
- Streaming registered decrementer: the inverse-direction companion of the team's registered +1 adder.
- Each accepted word produces in_data - STEP on the output, with a borrow flag.
- Both sides use a valid/ready handshake. A two-entry output buffer (main + skid) gives full throughput under backpressure with a registered in_ready.
- Sits between 8-bit datapath stages that need a back-pressurable decrement.

Parameters:
- WIDTH, 8, data width in bits.
- STEP, 1, decrement amount; legal range 1 to 2^WIDTH-1.
- SATURATE, 0:
  - 0: result wraps modulo 2^WIDTH.
  - 1: result clamps to 0 on underflow.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  block can accept a word this cycle; registered.
- in_data  in  WIDTH  operand.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  WIDTH  decremented result.
- out_borrow  out  1  high when in_data < STEP for this result.
- underflow_cnt  out  8  saturating count of borrows delivered downstream.

Behaviour:
- One clock; rst is synchronous and active-high, sampled on the rising edge of clk.
- Transfer rules:
  - Input transfer occurs when in_valid & in_ready at a clk edge.
  - Output transfer occurs when out_valid & out_ready at a clk edge.
- Arithmetic is computed on the input word at acceptance and stored with the word:
  - borrow = (in_data < STEP).
  - SATURATE=0: data = (in_data - STEP) mod 2^WIDTH.
  - SATURATE=1: data = borrow ? 0 : in_data - STEP.
  - out_borrow is 1 on every underflow in both modes.
- Storage: main register M (drives outputs) and skid register S, each with a valid bit.
- States, encoded by {M.v, S.v}:
  - EMPTY {0,0}
  - ONE {1,0}
  - FULL {1,1}
- in_ready = !S.v, registered. It is 1 in EMPTY and ONE, and 0 in FULL.
- Transitions:
  - EMPTY: accept -> ONE, result in M.
  - ONE, accept & no output transfer -> FULL, result in S.
  - ONE, accept & output transfer -> ONE, M <= new result.
  - ONE, output transfer only -> EMPTY.
  - FULL, output transfer -> ONE, M <= S. No accept is possible in FULL.
- Latency and throughput:
  - Latency is 1 cycle: a word accepted at edge N is on out_data after edge N, if M was free or transferring at edge N.
  - Sustained throughput is 1 word/cycle while out_ready=1.
- Order is strictly preserved; no word is dropped or duplicated.
- Output stability: while out_valid=1 and out_ready=0, out_data and out_borrow must hold.
- underflow_cnt:
  - Increments on each output transfer with out_borrow=1.
  - Saturates at 255 and never wraps.
  - Cleared only by rst.
- Reset:
  - Any edge with rst=1 empties M and S.
  - Reset values: out_valid=0, out_data=0, out_borrow=0, underflow_cnt=0, in_ready=1 from the first edge after rst deasserts.
  - Handshakes sampled in a cycle with rst=1 are ignored. Words in flight at reset mid-operation are discarded.
- Wrap boundaries (WIDTH=8, STEP=1):
  - 0x00 -> 0xFF with borrow=1; with SATURATE=1 the result is 0x00 with borrow=1.
  - 0x01 -> 0x00 with borrow=0.
  - 0xFF -> 0xFE with borrow=0.

Test Plan:
- Reset, then single word: rst for 2 cycles, then in_data=0x10, out_ready=1 -> out_data=0x0F, out_borrow=0, out_valid high exactly 1 cycle after acceptance; after reset in_ready=1 and out_valid=0.
- Wrap (SATURATE=0) and clamp (SATURATE=1) boundaries:
  - SATURATE=0: in_data sequence 0x00, 0x01, 0xFF -> 0xFF/b1, 0x00/b0, 0xFE/b0; underflow_cnt=1.
  - SATURATE=1, same sequence -> 0x00/b1, 0x00/b0, 0xFE/b0.
- Backpressure and skid fill:
  - Stimulus: stream 0x05, 0x06, 0x07 with out_ready=0.
  - Required: the first two words are accepted, then in_ready=0; out_data holds 0x04 stable.
  - Then out_ready=1 -> outputs 0x04, 0x05, 0x06 in order, one per cycle, and in_ready reasserts the cycle after the first output transfer.
- Full throughput: 256 back-to-back words 0x00..0xFF with out_ready=1 -> 256 outputs, one per cycle, each equal to the input minus 1 mod 256; underflow_cnt=1.
- Random valid/ready toggling, 1000 words, STEP=3 -> scoreboard matches (x-3) mod 256 in order; borrow set exactly when x<3; underflow_cnt saturates at 255 once borrows exceed 255.
- Reset mid-operation: assert rst while in FULL -> next cycle out_valid=0 and in_ready=1; no stale word emerges afterwards; underflow_cnt=0.
